// File: rtl/sw_job_arbiter_if.sv
// Job request, response and core-side signal bundle for sw_job_arbiter.
// slave: arbiter view; master: host + scoring core view.
interface sw_job_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*12-1:0] req_q;
  logic [NUM_REQ*20-1:0] req_r;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [1:0]            resp_id;
  logic [4:0]            resp_result;
  logic                  resp_timeout;
  logic [7:0]            jobs_done;
  logic                  sw_reset;
  logic                  sw_start;
  logic [11:0]           sw_q;
  logic [19:0]           sw_r;
  logic [4:0]            sw_result;
  logic                  sw_done;

  modport slave (
    input  req_valid, req_q, req_r,
    input  resp_ready, sw_result, sw_done,
    output req_ready, resp_valid, resp_id,
    output resp_result, resp_timeout, jobs_done,
    output sw_reset, sw_start, sw_q, sw_r
  );

  modport master (
    output req_valid, req_q, req_r,
    output resp_ready, sw_result, sw_done,
    input  req_ready, resp_valid, resp_id,
    input  resp_result, resp_timeout, jobs_done,
    input  sw_reset, sw_start, sw_q, sw_r
  );
endinterface

// File: rtl/sw_job_arbiter.sv
// Round-robin scheduler sharing one Smith-Waterman core among requesters.
// Ports: clock, reset (async active-low), bus (jobs, responses, core side).
module sw_job_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int START_CYCLES = 12,
  parameter int TIMEOUT      = 64
) (
  input  logic           clock,
  input  logic           reset,
  sw_job_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, WAIT, RESP
  } state_t;

  localparam logic [15:0] RUN_LAST  = 16'(START_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LAST_ID   = 2'(NUM_REQ - 1);

  state_t      state;
  logic [1:0]  prio;
  logic [1:0]  gnt;
  logic        found;
  logic [15:0] cnt;
  logic [11:0] sel_q;
  logic [19:0] sel_r;

  // Lowest valid index overall, overridden by the lowest
  // valid index at or above prio: a wrap-around scan.
  always_comb begin
    found = |bus.req_valid;
    gnt   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i])
        gnt = 2'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i] && 2'(i) >= prio)
        gnt = 2'(i);
  end

  always_comb begin
    sel_q         = '0;
    sel_r         = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == 2'(i)) begin
        sel_q = bus.req_q[12*i +: 12];
        sel_r = bus.req_r[20*i +: 20];
      end
      bus.req_ready[i] = reset && state == IDLE
                         && bus.req_valid[i]
                         && gnt == 2'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      prio             <= '0;
      cnt              <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_id      <= '0;
      bus.resp_result  <= '0;
      bus.resp_timeout <= 1'b0;
      bus.jobs_done    <= '0;
      bus.sw_reset     <= 1'b1;
      bus.sw_start     <= 1'b0;
      bus.sw_q         <= '0;
      bus.sw_r         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.sw_reset <= 1'b0;
          if (found) begin
            bus.sw_q     <= sel_q;
            bus.sw_r     <= sel_r;
            bus.resp_id  <= gnt;
            prio         <= (gnt == LAST_ID) ? 2'd0
                                             : gnt + 2'd1;
            bus.sw_reset <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          bus.sw_reset <= 1'b0;
          bus.sw_start <= 1'b1;
          cnt          <= '0;
          state        <= RUN;
        end
        RUN: begin
          if (cnt == RUN_LAST) begin
            bus.sw_start <= 1'b0;
            cnt          <= '0;
            state        <= WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT: begin
          if (bus.sw_done) begin
            bus.resp_result  <= bus.sw_result;
            bus.resp_timeout <= 1'b0;
            bus.resp_valid   <= 1'b1;
            state            <= RESP;
          end else if (cnt == WAIT_LAST) begin
            // Abort: kick the core back to a clean state.
            bus.resp_result  <= '0;
            bus.resp_timeout <= 1'b1;
            bus.resp_valid   <= 1'b1;
            bus.sw_reset     <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          bus.sw_reset <= 1'b0;
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.jobs_done  <= bus.jobs_done + 8'd1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
